// File: rtl/gate_sequencer.sv
// Half-bridge gate sequencer: enforces dead-time between complementary gates,
// a minimum on-time before reversal, and a latched fault shutdown.
module gate_sequencer #(
  parameter int DEADTIME = 10,
  parameter int MIN_ON   = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_sigma,
  input  logic        i_fault,
  output logic        o_gate_h,
  output logic        o_gate_l,
  output logic [2:0]  o_state,
  output logic [15:0] o_switch_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_H  = 3'd1,
    HIGH  = 3'd2,
    DT_L  = 3'd3,
    LOW   = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [15:0] DT_LAST  = 16'(DEADTIME - 1);
  localparam logic [15:0] MIN_ON_C = 16'(MIN_ON);

  state_t      state;
  state_t      next_state;
  logic [15:0] dt_cnt;
  logic [15:0] on_cnt;
  logic        entering;
  logic        turn_on;

  always_comb begin
    // NOTE: next_state gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    if (i_fault) begin
      next_state = FAULT;
    end else if (state == FAULT) begin
      if (!i_enable) next_state = IDLE;
    end else if (!i_enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = i_sigma ? DT_H : DT_L;
        DT_H:    if (dt_cnt == DT_LAST) next_state = HIGH;
        DT_L:    if (dt_cnt == DT_LAST) next_state = LOW;
        // A pending reversal waits here until the on-time is satisfied.
        HIGH:    if (!i_sigma && (on_cnt >= MIN_ON_C)) next_state = DT_L;
        LOW:     if (i_sigma && (on_cnt >= MIN_ON_C)) next_state = DT_H;
        default: next_state = IDLE;
      endcase
    end
  end

  assign entering = (next_state != state);
  assign turn_on  = entering && ((next_state == HIGH) || (next_state == LOW));

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      o_gate_h       <= 1'b0;
      o_gate_l       <= 1'b0;
      dt_cnt         <= '0;
      on_cnt         <= '0;
      o_switch_count <= '0;
    end else begin
      state    <= next_state;
      // Gates decode the state being entered, so they switch on the same edge.
      o_gate_h <= (next_state == HIGH);
      o_gate_l <= (next_state == LOW);

      if (entering) begin
        dt_cnt <= '0;
        on_cnt <= '0;
      end else begin
        if ((state == DT_H) || (state == DT_L)) dt_cnt <= dt_cnt + 16'd1;
        if (((state == HIGH) || (state == LOW)) && (on_cnt < MIN_ON_C))
          on_cnt <= on_cnt + 16'd1;
      end

      if (turn_on) o_switch_count <= o_switch_count + 16'd1;
    end
  end

  assign o_state = state;

  gates_exclusive: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(o_gate_h && o_gate_l));

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: table of timed vectors through a scoreboard queue,
// plus hand sequences for async reset and the 16-bit turn-on counter wrap.
module tb_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, sig = 1'b0, flt = 1'b0;
  logic        gate_h, gate_l;
  logic [2:0]  st;
  logic [15:0] cnt;

  logic        en_w = 1'b0, sig_w = 1'b0;
  logic        gate_h_w, gate_l_w;
  logic [2:0]  st_w;
  logic [15:0] cnt_w;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  gate_sequencer #(.DEADTIME(10), .MIN_ON(20)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_sigma(sig), .i_fault(flt),
    .o_gate_h(gate_h), .o_gate_l(gate_l), .o_state(st), .o_switch_count(cnt)
  );

  gate_sequencer #(.DEADTIME(1), .MIN_ON(1)) u_wrap (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en_w), .i_sigma(sig_w), .i_fault(1'b0),
    .o_gate_h(gate_h_w), .o_gate_l(gate_l_w), .o_state(st_w), .o_switch_count(cnt_w)
  );

  typedef struct {
    logic        en;
    logic        sig;
    logic        flt;
    int          n;
    logic [2:0]  st;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic        h;
    logic        l;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("excl_main", 32'(gate_h & gate_l), 32'd0);
      check("excl_wrap", 32'(gate_h_w & gate_l_w), 32'd0);
    end
  end

  function automatic vec_t mk(input logic e, input logic s, input logic f, input int n,
                              input logic [2:0] es, input logic [15:0] ec);
    vec_t v;
    v.en = e; v.sig = s; v.flt = f; v.n = n; v.st = es; v.cnt = ec;
    return v;
  endfunction

  initial begin
    exp_t e;
    string nm;

    // Timed vectors: drive, advance n edges, expect state/count.
    vecs.push_back(mk(1, 1, 0,  1, 3'd1, 16'd0)); // IDLE -> DT_H
    vecs.push_back(mk(1, 1, 0,  9, 3'd1, 16'd0)); // still dead-time
    vecs.push_back(mk(1, 1, 0,  1, 3'd2, 16'd1)); // HIGH after 10 cycles
    vecs.push_back(mk(1, 1, 0,  5, 3'd2, 16'd1));
    vecs.push_back(mk(1, 0, 0, 15, 3'd2, 16'd1)); // early reversal held off
    vecs.push_back(mk(1, 0, 0,  1, 3'd3, 16'd1)); // on-counter reached 20
    vecs.push_back(mk(1, 0, 0,  9, 3'd3, 16'd1));
    vecs.push_back(mk(1, 0, 0,  1, 3'd4, 16'd2)); // LOW after 10 cycles
    vecs.push_back(mk(1, 1, 0, 20, 3'd4, 16'd2));
    vecs.push_back(mk(1, 1, 0,  1, 3'd1, 16'd2));
    vecs.push_back(mk(1, 1, 0,  9, 3'd1, 16'd2));
    vecs.push_back(mk(1, 1, 0,  1, 3'd2, 16'd3));
    vecs.push_back(mk(1, 0, 0, 20, 3'd2, 16'd3));
    vecs.push_back(mk(1, 0, 0,  1, 3'd3, 16'd3));
    vecs.push_back(mk(1, 1, 0,  3, 3'd3, 16'd3)); // sigma toggles in DT_L
    vecs.push_back(mk(1, 0, 0,  3, 3'd3, 16'd3));
    vecs.push_back(mk(1, 1, 0,  2, 3'd3, 16'd3));
    vecs.push_back(mk(1, 1, 0,  1, 3'd3, 16'd3));
    vecs.push_back(mk(1, 1, 0,  1, 3'd4, 16'd4)); // LOW still reached
    vecs.push_back(mk(1, 1, 0, 20, 3'd4, 16'd4));
    vecs.push_back(mk(1, 1, 0,  1, 3'd1, 16'd4)); // DT_H after MIN_ON
    vecs.push_back(mk(0, 1, 0,  1, 3'd0, 16'd4)); // disable from dead-time
    vecs.push_back(mk(0, 1, 0,  3, 3'd0, 16'd4));
    vecs.push_back(mk(1, 0, 0, 10, 3'd3, 16'd4));
    vecs.push_back(mk(1, 0, 0,  1, 3'd4, 16'd5));
    vecs.push_back(mk(1, 0, 1,  1, 3'd5, 16'd5)); // fault in LOW
    vecs.push_back(mk(1, 0, 0,  3, 3'd5, 16'd5)); // latched while enabled
    vecs.push_back(mk(0, 0, 0,  1, 3'd0, 16'd5)); // exit needs enable low
    vecs.push_back(mk(0, 0, 0,  1, 3'd0, 16'd5));
    vecs.push_back(mk(1, 1, 0,  1, 3'd1, 16'd5));
    vecs.push_back(mk(0, 1, 1,  1, 3'd5, 16'd5)); // fault beats disable
    vecs.push_back(mk(0, 1, 1,  2, 3'd5, 16'd5));
    vecs.push_back(mk(0, 1, 0,  1, 3'd0, 16'd5));
    vecs.push_back(mk(1, 1, 0, 11, 3'd2, 16'd6));
    vecs.push_back(mk(0, 1, 0,  1, 3'd0, 16'd6)); // disable from HIGH
    vecs.push_back(mk(1, 1, 0, 11, 3'd2, 16'd7));

    // Asynchronous reset at start.
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(st), 32'd0);
    check("rst_gate_h", 32'(gate_h), 32'd0);
    check("rst_gate_l", 32'(gate_l), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    mon_en = 1'b1;
    step(1);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      en  = vecs[i].en;
      sig = vecs[i].sig;
      flt = vecs[i].flt;
      e.idx = i;
      e.st  = vecs[i].st;
      e.h   = (vecs[i].st == 3'd2);
      e.l   = (vecs[i].st == 3'd4);
      e.cnt = vecs[i].cnt;
      sb.push_back(e);
      step(vecs[i].n);
      e = sb.pop_front();
      nm = $sformatf("vec%0d", e.idx);
      check({nm, "_state"}, 32'(st), 32'(e.st));
      check({nm, "_gate_h"}, 32'(gate_h), 32'(e.h));
      check({nm, "_gate_l"}, 32'(gate_l), 32'(e.l));
      check({nm, "_count"}, 32'(cnt), 32'(e.cnt));
    end

    // Async reset while the high gate is on, between clock edges.
    check("pre_rst_gate_h", 32'(gate_h), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gate_h", 32'(gate_h), 32'd0);
    check("mid_rst_state", 32'(st), 32'd0);
    check("mid_rst_count", 32'(cnt), 32'd0);
    step(2);
    check("held_rst_state", 32'(st), 32'd0);
    #2 rst_n = 1'b1;
    step(1);
    check("restart_state", 32'(st), 32'd1);
    step(10);
    check("restart_high", 32'(gate_h), 32'd1);
    check("restart_count", 32'(cnt), 32'd1);
    en = 1'b0;
    step(1);

    // Wrap: DEADTIME=1, MIN_ON=1 gives one turn-on every 3 edges.
    for (int n = 1; n <= 196607; n++) begin
      en_w  = 1'b1;
      sig_w = (((n - 1) / 3) % 2 == 0);
      step(1);
      if (n == 2) begin
        check("wrap_first_state", 32'(st_w), 32'd2);
        check("wrap_first_count", 32'(cnt_w), 32'd1);
      end
      if (n == 5) begin
        check("wrap_second_state", 32'(st_w), 32'd4);
        check("wrap_second_count", 32'(cnt_w), 32'd2);
      end
      if (n == 196604) check("wrap_max_count", 32'(cnt_w), 32'd65535);
      if (n == 196607) begin
        check("wrap_zero_count", 32'(cnt_w), 32'd0);
        check("wrap_zero_gate_l", 32'(gate_l_w), 32'd1);
      end
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
